// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_pkg
// Description : Shared definitions for the SPI memory command sequencer:
//               default opcodes, default maximum burst length, the sequencer
//               state encoding and the byte-phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

  localparam int unsigned MAX_LEN_DEF = 16;
  localparam logic [7:0]  RD_OPC_DEF  = 8'h03;
  localparam logic [7:0]  WR_OPC_DEF  = 8'h02;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Which byte of the frame is currently being loaded / in flight.
  typedef enum logic [1:0] {
    PH_OPC     = 2'd0,
    PH_ADDR_HI = 2'd1,
    PH_ADDR_LO = 2'd2,
    PH_DATA    = 2'd3
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/spi_byte_issuer.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_issuer
// Description : Per-byte start/done handshake towards the SPI byte master.
//               Holds the byte to send, fires a single-cycle start once the
//               master is idle, and reports completion on the matching done.
// Ports       : clk, reset_n       - clock, async active-low reset
//               load_i, byte_i     - capture the next byte to send
//               issue_i            - request a start for the captured byte
//               spi_busy_i         - master busy, start is held off
//               spi_done_i         - master finished the byte in flight
//               spi_start_o        - one-cycle start pulse
//               spi_data_o         - byte presented to the master
//               done_o             - byte in flight has completed
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_issuer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       issue_i,
  input  logic       spi_busy_i,
  input  logic       spi_done_i,
  output logic       spi_start_o,
  output logic [7:0] spi_data_o,
  output logic       done_o
);

  logic [7:0] data_q;
  logic       pend_q;   // a start has been sent and its done not yet seen

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 8'h00;
      pend_q <= 1'b0;
    end else begin
      if (load_i) begin
        data_q <= byte_i;
      end
      if (spi_start_o) begin
        pend_q <= 1'b1;
      end else if (pend_q && spi_done_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  // A done that is not paired with an outstanding start is simply dropped.
  assign spi_start_o = issue_i && !spi_busy_i && !pend_q;
  assign done_o      = pend_q && spi_done_i;
  assign spi_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/spi_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_seq
// Description : SPI memory command sequencer. Turns a read/write command into
//               the byte frame opcode, addr[15:8], addr[7:0], data bytes and
//               drives it through a byte-level SPI master.
// Config      : SPI_MEM_SEQ_WRITE_EN - when defined, write commands are
//               supported; otherwise a write command is rejected with err
//               and the write-data path is absent.
// Ports       : clk, reset_n                    - clock, async active-low reset
//               cmd_valid/cmd_ready             - command handshake
//               cmd_wr, cmd_addr, cmd_len       - command fields
//               wdata, wdata_valid, wdata_ready - write byte stream
//               rdata, rdata_valid              - read byte output (pulse)
//               spi_data_in, spi_start          - byte/start to SPI master
//               spi_busy, spi_done, spi_data_out- status/byte from SPI master
//               busy, done, err                 - sequencer status
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_seq
  import spi_mem_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter logic [7:0]  RD_OPC  = RD_OPC_DEF,
  parameter logic [7:0]  WR_OPC  = WR_OPC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic [7:0]  wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic [7:0]  spi_data_in,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic        spi_done,
  input  logic [7:0]  spi_data_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [15:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q;
  logic             rdata_valid_q;

  logic       w_accept;
  logic       w_len_bad;
  logic       w_illegal;
  logic [7:0] w_opc;
  logic [7:0] w_data_byte;   // byte to send during the data phase
  logic       w_data_avail;  // data-phase byte is ready to be loaded
  logic       w_txn_rd;      // current transaction returns read data
  logic       w_wdata_ready;
  logic [7:0] w_byte;
  logic       w_byte_avail;
  logic       w_load;
  logic       w_issue;
  logic       w_start;
  logic       w_byte_done;

  assign w_accept  = cmd_valid && (state_q == IDLE);
  assign w_len_bad = (cmd_len == 5'd0) || (32'(cmd_len) > MAX_LEN);

`ifdef SPI_MEM_SEQ_WRITE_EN
  logic wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b0;
    end else if (w_accept) begin
      wr_q <= cmd_wr;
    end
  end

  assign w_illegal     = w_len_bad;
  assign w_opc         = wr_q ? WR_OPC : RD_OPC;
  assign w_data_byte   = wr_q ? wdata : 8'h00;
  assign w_data_avail  = !wr_q || wdata_valid;
  assign w_txn_rd      = !wr_q;
  // Ready is offered only in the cycle the byte is actually taken, so it
  // pulses once per data byte even when the stream stalls.
  assign w_wdata_ready = (state_q == LOAD) && (phase_q == PH_DATA) && wr_q && wdata_valid;
`else
  logic unused_wdata;

  assign unused_wdata  = ^{wdata, wdata_valid};
  assign w_illegal     = w_len_bad || cmd_wr;
  assign w_opc         = RD_OPC;
  assign w_data_byte   = 8'h00;
  assign w_data_avail  = 1'b1;
  assign w_txn_rd      = 1'b1;
  assign w_wdata_ready = 1'b0;
`endif

  // Byte selected for the current phase of the frame.
  always_comb begin
    w_byte = 8'h00;
    unique case (phase_q)
      PH_OPC:     w_byte = w_opc;
      PH_ADDR_HI: w_byte = addr_q[15:8];
      PH_ADDR_LO: w_byte = addr_q[7:0];
      PH_DATA:    w_byte = w_data_byte;
      default:    w_byte = 8'h00;
    endcase
  end

  assign w_byte_avail = (phase_q != PH_DATA) || w_data_avail;
  assign w_load       = (state_q == LOAD) && w_byte_avail;
  assign w_issue      = (state_q == ISSUE);

  spi_byte_issuer u_issuer (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (w_load),
    .byte_i      (w_byte),
    .issue_i     (w_issue),
    .spi_busy_i  (spi_busy),
    .spi_done_i  (spi_done),
    .spi_start_o (w_start),
    .spi_data_o  (spi_data_in),
    .done_o      (w_byte_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= PH_OPC;
      remain_q <= '0;
      addr_q   <= 16'h0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    addr_d   = addr_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = CNT_W'(cmd_len);
          phase_d  = PH_OPC;
          err_d    = w_illegal;
          // Illegal commands skip the SPI traffic and report straight away.
          state_d  = w_illegal ? FINISH : LOAD;
        end
      end
      LOAD: begin
        if (w_byte_avail) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (w_start) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (w_byte_done) begin
          if (phase_q != PH_DATA) begin
            phase_d = phase_e'(phase_q + 2'd1);
            state_d = LOAD;
          end else begin
            remain_d = remain_q - 1'b1;
            state_d  = (remain_q == CNT_W'(1)) ? FINISH : LOAD;
          end
        end
      end
      FINISH: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      if (w_byte_done && (phase_q == PH_DATA) && w_txn_rd) begin
        rdata_q       <= spi_data_out;
        rdata_valid_q <= 1'b1;
      end
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign err         = (state_q == FINISH) && err_q;
  assign spi_start   = w_start;
  assign wdata_ready = w_wdata_ready;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_seq
// Description : Self-checking bench for spi_mem_seq with a behavioural
//               byte-level SPI master model. Honours SPI_MEM_SEQ_WRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_seq;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic [7:0]  spi_data_in;
  logic        spi_start;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_data_out;
  logic        busy;
  logic        done;
  logic        err;

  logic         model_done;
  logic         stray_done;
  logic         clr;
  logic [127:0] rsp_vec;
  int           spi_lat;

  assign spi_done = model_done | stray_done;

  spi_mem_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wdata        (wdata),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .spi_data_in  (spi_data_in),
    .spi_start    (spi_start),
    .spi_busy     (spi_busy),
    .spi_done     (spi_done),
    .spi_data_out (spi_data_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI master model: busy for spi_lat cycles after a start, then one done
  // pulse. Data bytes (4th start onwards) answer with bytes of rsp_vec.
  int   m_cnt;
  int   m_k;
  int   m_idx;
  logic [7:0] m_rsp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_busy     <= 1'b0;
      model_done   <= 1'b0;
      spi_data_out <= 8'h00;
      m_cnt        <= 0;
      m_k          <= 0;
      m_rsp        <= 8'h00;
    end else begin
      model_done <= 1'b0;
      if (clr) begin
        m_k <= 0;
      end
      if (spi_start) begin
        spi_busy <= 1'b1;
        m_cnt    <= spi_lat;
        m_idx     = m_k - 3;
        if (m_idx >= 0 && m_idx < 16) m_rsp <= rsp_vec[m_idx*8 +: 8];
        else                          m_rsp <= 8'hEE;
        m_k <= m_k + 1;
      end else if (spi_busy) begin
        if (m_cnt <= 1) begin
          spi_busy     <= 1'b0;
          model_done   <= 1'b1;
          spi_data_out <= m_rsp;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  logic [7:0] sent_q[$];
  logic [7:0] rd_q[$];
  int n_done, n_err, n_errdone, n_wr, n_acc;

  always @(negedge clk) begin
    if (clr) begin
      sent_q.delete();
      rd_q.delete();
      n_done = 0; n_err = 0; n_errdone = 0; n_wr = 0; n_acc = 0;
    end else begin
      if (spi_start)             sent_q.push_back(spi_data_in);
      if (rdata_valid)           rd_q.push_back(rdata);
      if (done)                  n_done++;
      if (err)                   n_err++;
      if (err && done)           n_errdone++;
      if (wdata_ready)           n_wr++;
      if (cmd_valid && cmd_ready) n_acc++;
    end
  end

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 clr = 1'b0;
  endtask

  // Issue one command and wait (bounded) for done.
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [4:0] len,
                         input logic [7:0] wd, input int wd_delay,
                         output logic timed_out, output int snap);
    do_clr();
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    timed_out = 1'b1;
    snap      = -1;
    for (int c = 0; c < 3000; c++) begin
      if (wr && c == wd_delay) begin
        snap = sent_q.size();
        wdata = wd; wdata_valid = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1 wdata_valid = 1'b0;
  endtask

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [4:0]   len;
    logic [7:0]   wd;
    logic [127:0] rsp;
    logic         exp_err;
    int           exp_nstart;
    logic [23:0]  exp_hdr;
    logic [7:0]   exp_dbyte;
    int           exp_nrd;
    int           exp_nwr;
  } vec_t;

  vec_t vecs[7];

  logic to;
  int   snap;

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'h0; cmd_len = 5'd0;
    wdata = 8'h00; wdata_valid = 1'b0; stray_done = 1'b0; clr = 1'b0;
    rsp_vec = '0; spi_lat = 3;
    #1;
    check("reset_outputs",
          {cmd_ready, busy, done, err, spi_start, rdata_valid, wdata_ready, spi_data_in, rdata},
          23'h400000);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    //          wr    addr      len    wd     rsp                                         err nst hdr         db     nrd nwr
    vecs[0] = '{1'b0, 16'h1234, 5'd2,  8'h00, 128'h3CA5,                                  1'b0, 5,  24'h031234, 8'h00, 2,  0};
    vecs[1] = '{1'b0, 16'h1111, 5'd0,  8'h00, 128'h0,                                     1'b1, 0,  24'h0,      8'h00, 0,  0};
    vecs[2] = '{1'b0, 16'h2222, 5'd17, 8'h00, 128'h0,                                     1'b1, 0,  24'h0,      8'h00, 0,  0};
`ifdef SPI_MEM_SEQ_WRITE_EN
    vecs[3] = '{1'b1, 16'h00FF, 5'd1,  8'h5A, 128'h0,                                     1'b0, 4,  24'h0200FF, 8'h5A, 0,  1};
`else
    vecs[3] = '{1'b1, 16'h00FF, 5'd1,  8'h5A, 128'h0,                                     1'b1, 0,  24'h0,      8'h00, 0,  0};
`endif
    vecs[4] = '{1'b0, 16'hABCD, 5'd1,  8'h00, 128'h77,                                    1'b0, 4,  24'h03ABCD, 8'h00, 1,  0};
    vecs[5] = '{1'b0, 16'h8001, 5'd16, 8'h00, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F,      1'b0, 19, 24'h038001, 8'h00, 16, 0};
    vecs[6] = '{1'b0, 16'h3333, 5'd31, 8'h00, 128'h0,                                     1'b1, 0,  24'h0,      8'h00, 0,  0};

    for (int i = 0; i < 7; i++) begin
      rsp_vec = vecs[i].rsp;
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wd, 0, to, snap);
      check($sformatf("row%0d_timeout", i), to, 1'b0);
      check($sformatf("row%0d_err", i), n_err, vecs[i].exp_err);
      check($sformatf("row%0d_errdone", i), n_errdone, vecs[i].exp_err);
      check($sformatf("row%0d_done", i), n_done, 1);
      check($sformatf("row%0d_nstart", i), sent_q.size(), vecs[i].exp_nstart);
      if (vecs[i].exp_nstart >= 3 && sent_q.size() == vecs[i].exp_nstart) begin
        check($sformatf("row%0d_hdr", i), {sent_q[0], sent_q[1], sent_q[2]}, vecs[i].exp_hdr);
        for (int j = 3; j < vecs[i].exp_nstart; j++)
          check($sformatf("row%0d_dbyte%0d", i, j - 3), sent_q[j], vecs[i].exp_dbyte);
      end
      check($sformatf("row%0d_nrd", i), rd_q.size(), vecs[i].exp_nrd);
      for (int j = 0; j < rd_q.size() && j < vecs[i].exp_nrd; j++)
        check($sformatf("row%0d_rdata%0d", i, j), rd_q[j], vecs[i].rsp[j*8 +: 8]);
      check($sformatf("row%0d_nwr", i), n_wr, vecs[i].exp_nwr);
    end

`ifdef SPI_MEM_SEQ_WRITE_EN
    // Write with late data: the data byte must wait for wdata_valid.
    run_cmd(1'b1, 16'h00FF, 5'd1, 8'h5A, 30, to, snap);
    check("wstall_timeout", to, 1'b0);
    check("wstall_starts_before_data", snap, 3);
    check("wstall_nstart", sent_q.size(), 4);
    if (sent_q.size() == 4)
      check("wstall_bytes", {sent_q[0], sent_q[1], sent_q[2], sent_q[3]}, 32'h0200FF5A);
    check("wstall_nwr", n_wr, 1);
    check("wstall_done", n_done, 1);
    check("wstall_err", n_err, 0);
`else
    // Write rejected: no SPI traffic, no write-data handshake.
    run_cmd(1'b1, 16'h00FF, 5'd1, 8'h5A, 30, to, snap);
    check("wrej_timeout", to, 1'b0);
    check("wrej_errdone", n_errdone, 1);
    check("wrej_nstart", sent_q.size(), 0);
    check("wrej_nwr", n_wr, 0);
`endif

    // Reset in the middle of the address phase.
    rsp_vec = 128'h42;
    do_clr();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h1234; cmd_len = 5'd2;
    @(posedge clk); #1 cmd_valid = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sent_q.size() >= 2) begin
        to = 1'b0;
        break;
      end
    end
    check("rst_reach_addr", to, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          {cmd_ready, busy, done, err, spi_start, rdata_valid, wdata_ready, spi_data_in, rdata},
          23'h400000);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    check("rst_no_done", n_done, 0);
    check("rst_no_err", n_err, 0);
    rsp_vec = 128'h9C;
    run_cmd(1'b0, 16'h4321, 5'd1, 8'h00, 0, to, snap);
    check("rst_after_timeout", to, 1'b0);
    check("rst_after_nstart", sent_q.size(), 4);
    if (sent_q.size() == 4)
      check("rst_after_bytes", {sent_q[0], sent_q[1], sent_q[2], sent_q[3]}, 32'h03432100);
    check("rst_after_nrd", rd_q.size(), 1);
    if (rd_q.size() == 1) check("rst_after_rdata", rd_q[0], 8'h9C);

    // cmd_valid held high across a transaction.
    do_clr();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h4242; cmd_len = 5'd1;
    to = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (n_acc >= 2) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int c = 0; c < 500 && n_done < 2; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("held_timeout", to, 1'b0);
    check("held_accepts", n_acc, 2);
    check("held_done", n_done, 2);
    check("held_nstart", sent_q.size(), 8);
    check("held_nrd", rd_q.size(), 2);

    // Stray done while idle.
    do_clr();
    stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_idle", {cmd_ready, busy}, 2'b10);
    check("stray_nrd", rd_q.size(), 0);
    check("stray_done", n_done, 0);
    rsp_vec = 128'h61;
    run_cmd(1'b0, 16'h5A5A, 5'd1, 8'h00, 0, to, snap);
    check("stray_after_nstart", sent_q.size(), 4);
    check("stray_after_nrd", rd_q.size(), 1);
    if (rd_q.size() == 1) check("stray_after_rdata", rd_q[0], 8'h61);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
